// File: rtl/seg_serial_driver.sv
// seg_serial_driver: serialises packed 7-segment patterns into the display shift-register chain.
// Sequence: snapshot, shift MSB first on seg_clk/seg_dat, pulse seg_latch, then a one-cycle done.
// Optional feature: define SEG_AUTO_REFRESH_EN to auto-start a frame after REFRESH_GAP idle cycles.
module seg_serial_driver #(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned REFRESH_GAP = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [8*NUM_DIGITS-1:0]   segnum,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      seg_clk,
  output logic                      seg_dat,
  output logic                      seg_latch,
  output logic                      seg_clr_n
);

  localparam int unsigned NB = 8 * NUM_DIGITS;
  localparam int unsigned BW = $clog2(NB + 1);
  localparam int unsigned DW = $clog2(CLK_DIV + 1);

  // Reject parameter values the timing scheme cannot express.
  if (NUM_DIGITS == 0) begin : g_bad_digits
    $error("NUM_DIGITS must be >= 1");
  end
  if (CLK_DIV == 0) begin : g_bad_div
    $error("CLK_DIV must be >= 1");
  end
  if (REFRESH_GAP == 0) begin : g_bad_gap
    $error("REFRESH_GAP must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LATCH
  } state_t;

  state_t          state, state_nx;
  logic [DW-1:0]   div_cnt, div_nx;
  logic [BW-1:0]   bit_cnt, bit_nx;
  logic            phase, phase_nx;
  // Bits still to be shifted after the one currently on seg_dat.
  logic [NB-2:0]   rest, rest_nx;
  logic            busy_nx, done_nx, clk_nx, dat_nx, latch_nx;
  logic            go_c;

`ifdef SEG_AUTO_REFRESH_EN
  localparam int unsigned GW = $clog2(REFRESH_GAP + 1);
  logic [GW-1:0]   gap_cnt, gap_nx;
`endif

  // Frame launch decision while idle.
  always_comb begin
`ifdef SEG_AUTO_REFRESH_EN
    go_c   = 1'b0;
    gap_nx = '0;
    if (state == ST_IDLE) begin
      go_c = start || (gap_cnt == GW'(REFRESH_GAP - 1));
      gap_nx = go_c ? '0 : gap_cnt + GW'(1);
    end
`else
    go_c = (state == ST_IDLE) && start;
`endif
  end

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    state_nx = state;
    div_nx   = div_cnt;
    bit_nx   = bit_cnt;
    phase_nx = phase;
    rest_nx  = rest;
    busy_nx  = busy;
    done_nx  = 1'b0;
    clk_nx   = seg_clk;
    dat_nx   = seg_dat;
    latch_nx = seg_latch;

    case (state)
      ST_IDLE: begin
        busy_nx  = 1'b0;
        clk_nx   = 1'b0;
        dat_nx   = 1'b0;
        latch_nx = 1'b0;
        if (go_c) begin
          state_nx = ST_SHIFT;
          div_nx   = '0;
          bit_nx   = '0;
          phase_nx = 1'b0;
          rest_nx  = segnum[NB-2:0];
          busy_nx  = 1'b1;
          dat_nx   = segnum[NB-1];
        end
      end

      ST_SHIFT: begin
        if (div_cnt == DW'(CLK_DIV - 1)) begin
          div_nx = '0;
          if (!phase) begin
            phase_nx = 1'b1;
            clk_nx   = 1'b1;
          end else begin
            phase_nx = 1'b0;
            clk_nx   = 1'b0;
            if (bit_cnt == BW'(NB - 1)) begin
              state_nx = ST_LATCH;
              latch_nx = 1'b1;
              dat_nx   = 1'b0;
            end else begin
              bit_nx  = bit_cnt + BW'(1);
              dat_nx  = rest[NB-2];
              rest_nx = {rest[NB-3:0], 1'b0};
            end
          end
        end else begin
          div_nx = div_cnt + DW'(1);
        end
      end

      ST_LATCH: begin
        if (div_cnt == DW'(CLK_DIV - 1)) begin
          state_nx = ST_IDLE;
          div_nx   = '0;
          busy_nx  = 1'b0;
          latch_nx = 1'b0;
          done_nx  = 1'b1;
        end else begin
          div_nx = div_cnt + DW'(1);
        end
      end

      default: begin
        state_nx = ST_IDLE;
        busy_nx  = 1'b0;
        clk_nx   = 1'b0;
        dat_nx   = 1'b0;
        latch_nx = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs; reset clears the chain and aborts any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      phase     <= 1'b0;
      rest      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      seg_clk   <= 1'b0;
      seg_dat   <= 1'b0;
      seg_latch <= 1'b0;
      seg_clr_n <= 1'b0;
    end else begin
      state     <= state_nx;
      div_cnt   <= div_nx;
      bit_cnt   <= bit_nx;
      phase     <= phase_nx;
      rest      <= rest_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      seg_clk   <= clk_nx;
      seg_dat   <= dat_nx;
      seg_latch <= latch_nx;
      seg_clr_n <= 1'b1;
    end
  end

`ifdef SEG_AUTO_REFRESH_EN
  // Idle gap counter for automatic refresh frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt <= '0;
    end else begin
      gap_cnt <= gap_nx;
    end
  end
`endif

endmodule

// File: tb/tb_seg_serial_driver.sv
// Testbench for seg_serial_driver: random stimulus checked against a cycle-position frame model.
module tb_seg_serial_driver;

  localparam int ND = 3;
  localparam int D  = 2;
  localparam int NB = 8 * ND;
  localparam int SH = 2 * NB * D;
  localparam int FL = SH + D;

  logic          clk;
  logic          rst;
  logic          start;
  logic [NB-1:0] segnum;
  logic          busy, done, seg_clk, seg_dat, seg_latch, seg_clr_n;
  logic [5:0]    outs;

  int checks;
  int errors;
  int cyc;

  // Model: position of the current cycle inside a frame (1..FL busy, FL+1 done cycle).
  bit            m_active;
  int            m_t;
  logic [NB-1:0] m_snap;
  bit            m_clr;

  // Scoreboard of bits sampled on DUT seg_clk rising edges.
  logic [NB-1:0] cap;
  int            rises;
  logic          prev_clk;

  seg_serial_driver #(
    .NUM_DIGITS (ND),
    .CLK_DIV    (D),
    .REFRESH_GAP(10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .segnum   (segnum),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .seg_clk  (seg_clk),
    .seg_dat  (seg_dat),
    .seg_latch(seg_latch),
    .seg_clr_n(seg_clr_n)
  );

  assign outs = {busy, done, seg_clk, seg_dat, seg_latch, seg_clr_n};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {busy,done,seg_clk,seg_dat,seg_latch,seg_clr_n} from the frame position.
  function automatic logic [5:0] expect_out();
    logic b, d, c, dt, l;
    b = 1'b0; d = 1'b0; c = 1'b0; dt = 1'b0; l = 1'b0;
    if (m_active) begin
      if (m_t <= SH) begin
        b  = 1'b1;
        c  = ((m_t - 1) % (2 * D)) >= D;
        dt = m_snap[NB - 1 - (m_t - 1) / (2 * D)];
      end else if (m_t <= FL) begin
        b = 1'b1;
        l = 1'b1;
      end else begin
        d = 1'b1;
      end
    end
    return {b, d, c, dt, l, m_clr};
  endfunction

  // One clock: drive inputs, advance the model at the edge, compare at the falling edge.
  task automatic tick(input logic r, input logic s, input logic [NB-1:0] seg);
    rst    = r;
    start  = s;
    segnum = seg;
    @(posedge clk);
    if (r) begin
      m_active = 1'b0;
      m_t      = 0;
      m_clr    = 1'b0;
    end else begin
      m_clr = 1'b1;
      if ((!m_active || m_t == FL + 1) && s) begin
        m_active = 1'b1;
        m_t      = 1;
        m_snap   = seg;
      end else if (m_active && m_t <= FL) begin
        m_t++;
      end else begin
        m_active = 1'b0;
        m_t      = 0;
      end
    end
    @(negedge clk);
    cyc++;
    check($sformatf("outputs cycle %0d", cyc), 32'(outs), 32'(expect_out()));
    if (r || (m_active && m_t == 1)) begin
      cap   = '0;
      rises = 0;
    end else if (seg_clk && !prev_clk) begin
      cap = {cap[NB-2:0], seg_dat};
      rises++;
    end
    prev_clk = seg_clk;
    if (m_active && m_t == FL + 1) begin
      check($sformatf("frame data cycle %0d", cyc), 32'(cap), 32'(m_snap));
      check($sformatf("clk rises cycle %0d", cyc), 32'(rises), 32'(NB));
    end
  endtask

  initial begin
    int first_done, first_latch, last_done;
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    m_active = 1'b0;
    m_t      = 0;
    m_snap   = '0;
    m_clr    = 1'b0;
    cap      = '0;
    rises    = 0;
    prev_clk = 1'b0;
    rst      = 1'b1;
    start    = 1'b0;
    segnum   = '0;

    // Reset for three cycles, then idle.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, NB'($urandom));
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, NB'($urandom));

    // Directed frame: latch and done positions relative to the accepting edge.
    first_done  = 0;
    first_latch = 0;
    tick(1'b0, 1'b1, 24'hA5_3C_F0);
    for (int i = 2; i <= 110; i++) begin
      tick(1'b0, 1'b0, NB'($urandom));
      if (seg_latch && first_latch == 0) first_latch = i;
      if (done && first_done == 0) first_done = i;
    end
    check("first latch cycle", 32'(first_latch), 32'd97);
    check("done cycle", 32'(first_done), 32'd99);

    // Start held high: back-to-back frames, done every 99 cycles.
    last_done = 0;
    for (int i = 1; i <= 320; i++) begin
      tick(1'b0, 1'b1, NB'($urandom));
      if (done) begin
        if (last_done != 0) check("done spacing", 32'(i - last_done), 32'd99);
        last_done = i;
      end
    end
    for (int i = 0; i < 110; i++) tick(1'b0, 1'b0, NB'($urandom));

    // Start pulses mid-frame with changing segnum are ignored.
    for (int i = 1; i <= 110; i++)
      tick(1'b0, (i == 1 || i == 10 || i == 40), NB'($urandom));

    // Reset mid-frame aborts it; the next start shifts a full frame.
    for (int i = 1; i <= 49; i++) tick(1'b0, (i == 1), NB'($urandom));
    tick(1'b1, 1'b0, NB'($urandom));
    tick(1'b1, 1'b1, NB'($urandom));
    tick(1'b0, 1'b0, NB'($urandom));
    for (int i = 1; i <= 105; i++) tick(1'b0, (i == 1), NB'($urandom));

    // Random traffic with occasional resets.
    for (int i = 0; i < 2500; i++)
      tick(($urandom_range(499) == 0), ($urandom_range(19) == 0), NB'($urandom));
    for (int i = 0; i < 110; i++) tick(1'b0, 1'b0, NB'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
